// File: rtl/hazard_ctrl_if.sv
// Hazard unit port bundle: ID/EX pipeline
// inputs toward the unit, stall/flush controls back.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] IDRegRs;
  logic [REG_AW-1:0] IDRegRt;
  logic [REG_AW-1:0] EXRegRt;
  logic              EXMemRead;
  logic              EXMduStart;
  logic              IDHiLoUse;
  logic              IDBranchTaken;
  logic              PCWrite;
  logic              IFIDWrite;
  logic              HazMuxCon;
  logic              IFIDFlush;
  logic              MduBusy;
  logic [CNT_W-1:0]  StallCycles;

  modport master (
    output IDRegRs, IDRegRt, EXRegRt,
    output EXMemRead, EXMduStart,
    output IDHiLoUse, IDBranchTaken,
    input  PCWrite, IFIDWrite, HazMuxCon,
    input  IFIDFlush, MduBusy, StallCycles
  );

  modport slave (
    input  IDRegRs, IDRegRt, EXRegRt,
    input  EXMemRead, EXMduStart,
    input  IDHiLoUse, IDBranchTaken,
    output PCWrite, IFIDWrite, HazMuxCon,
    output IFIDFlush, MduBusy, StallCycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: load-use and mul/div
// stalls, branch flush, stall-cycle counter.
module hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int MDU_LAT  = 8,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        reset,
  hazard_ctrl_if.slave hz
);

  localparam logic [3:0] LD_INIT = 4'(LOAD_LAT - 1);
  localparam logic [7:0] MD_INIT = 8'(MDU_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] ex_rt;

  logic [3:0]       ld_cnt_q, ld_cnt_d;
  logic [7:0]       md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic ld_hit;
  logic md_haz;
  logic stall;
  logic run;

  assign id_rs = hz.IDRegRs;
  assign id_rt = hz.IDRegRt;
  assign ex_rt = hz.EXRegRt;

  // Hazard detection; r0 never creates a dependency
  always_comb begin
    ld_hit = 1'b0;
    md_haz = 1'b0;
    stall  = 1'b0;
    ld_hit = hz.EXMemRead
           & (ex_rt != '0)
           & ((ex_rt == id_rs) | (ex_rt == id_rt));
    md_haz = hz.IDHiLoUse & (md_cnt_q != '0);
    stall  = ld_hit | (ld_cnt_q != '0) | md_haz;
  end

  // Counter next-state; a new hit/start restarts
  always_comb begin
    ld_cnt_d    = ld_cnt_q;
    md_cnt_d    = md_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (reset) begin
      ld_cnt_d    = '0;
      md_cnt_d    = '0;
      stall_cnt_d = '0;
    end else begin
      if (ld_hit)
        ld_cnt_d = LD_INIT;
      else if (ld_cnt_q != '0)
        ld_cnt_d = ld_cnt_q - 4'd1;
      if (hz.EXMduStart)
        md_cnt_d = MD_INIT;
      else if (md_cnt_q != '0)
        md_cnt_d = md_cnt_q - 8'd1;
      if (stall && stall_cnt_q != CNT_MAX)
        stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Control outputs; reset holds the front end
  always_comb begin
    run           = ~stall & ~reset;
    hz.PCWrite    = run;
    hz.IFIDWrite  = run;
    hz.HazMuxCon  = run;
    hz.IFIDFlush  = hz.IDBranchTaken & run;
    hz.MduBusy    = (md_cnt_q != '0) & ~reset;
    hz.StallCycles = stall_cnt_q;
  end

  // State registers
  always_ff @(posedge clk) begin
    ld_cnt_q    <= ld_cnt_d;
    md_cnt_q    <= md_cnt_d;
    stall_cnt_q <= stall_cnt_d;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances
// (LOAD_LAT=1/MDU_LAT=8, LOAD_LAT=3/MDU_LAT=4/CNT_W=3).
module tb_hazard_ctrl;

  typedef struct {
    string       nm;
    logic        pa;
    logic        pb;
    logic        fa;
    logic        fb;
    logic        ba;
    logic        bb;
    logic [15:0] ca;
    logic [2:0]  cb;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic memrd, mdust, hilo, br;

  int checks = 0;
  int errors = 0;
  exp_t q[$];
  logic [15:0] mca;
  logic [2:0]  mcb;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) ifa ();
  hazard_ctrl_if #(.REG_AW(5), .CNT_W(3))  ifb ();

  assign ifa.IDRegRs       = id_rs;
  assign ifa.IDRegRt       = id_rt;
  assign ifa.EXRegRt       = ex_rt;
  assign ifa.EXMemRead     = memrd;
  assign ifa.EXMduStart    = mdust;
  assign ifa.IDHiLoUse     = hilo;
  assign ifa.IDBranchTaken = br;
  assign ifb.IDRegRs       = id_rs;
  assign ifb.IDRegRt       = id_rt;
  assign ifb.EXRegRt       = ex_rt;
  assign ifb.EXMemRead     = memrd;
  assign ifb.EXMduStart    = mdust;
  assign ifb.IDHiLoUse     = hilo;
  assign ifb.IDBranchTaken = br;

  hazard_ctrl #(
    .REG_AW(5), .LOAD_LAT(1), .MDU_LAT(8), .CNT_W(16)
  ) u_a (.clk(clk), .reset(rst), .hz(ifa));

  hazard_ctrl #(
    .REG_AW(5), .LOAD_LAT(3), .MDU_LAT(4), .CNT_W(3)
  ) u_b (.clk(clk), .reset(rst), .hz(ifb));

  task automatic clr();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    memrd = 1'b0; mdust = 1'b0; hilo = 1'b0; br = 1'b0;
  endtask

  task automatic hit(input logic [4:0] r);
    memrd = 1'b1; ex_rt = r; id_rs = r;
  endtask

  // One cycle: push expectation, observe at negedge, advance.
  task automatic cycle(input string nm,
                       input logic sa, input logic sb,
                       input logic ba, input logic bb);
    exp_t e;
    exp_t g;
    e.nm = nm;
    e.pa = ~sa & ~rst;
    e.pb = ~sb & ~rst;
    e.fa = br & ~sa & ~rst;
    e.fb = br & ~sb & ~rst;
    e.ba = ba & ~rst;
    e.bb = bb & ~rst;
    e.ca = mca;
    e.cb = mcb;
    q.push_back(e);
    @(negedge clk);
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      g = q.pop_front();
      if ({ifa.PCWrite, ifa.IFIDWrite, ifa.HazMuxCon} !== {3{g.pa}}) begin
        errors++;
        $display("FAIL %s A pc/ifid/mux: got %b%b%b exp %b", g.nm,
                 ifa.PCWrite, ifa.IFIDWrite, ifa.HazMuxCon, g.pa);
      end
      checks++;
      if ({ifb.PCWrite, ifb.IFIDWrite, ifb.HazMuxCon} !== {3{g.pb}}) begin
        errors++;
        $display("FAIL %s B pc/ifid/mux: got %b%b%b exp %b", g.nm,
                 ifb.PCWrite, ifb.IFIDWrite, ifb.HazMuxCon, g.pb);
      end
      checks++;
      if ({ifa.IFIDFlush, ifb.IFIDFlush} !== {g.fa, g.fb}) begin
        errors++;
        $display("FAIL %s flush A/B: got %b%b exp %b%b", g.nm,
                 ifa.IFIDFlush, ifb.IFIDFlush, g.fa, g.fb);
      end
      checks++;
      if ({ifa.MduBusy, ifb.MduBusy} !== {g.ba, g.bb}) begin
        errors++;
        $display("FAIL %s busy A/B: got %b%b exp %b%b", g.nm,
                 ifa.MduBusy, ifb.MduBusy, g.ba, g.bb);
      end
      checks++;
      if (ifa.StallCycles !== g.ca || ifb.StallCycles !== g.cb) begin
        errors++;
        $display("FAIL %s stallcnt A/B: got %0d/%0d exp %0d/%0d", g.nm,
                 ifa.StallCycles, ifb.StallCycles, g.ca, g.cb);
      end
    end
    if (rst) begin
      mca = '0;
      mcb = '0;
    end else begin
      if (sa && mca != 16'hffff) mca = mca + 16'd1;
      if (sb && mcb != 3'd7) mcb = mcb + 3'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hit(5'd5); mdust = 1'b1; hilo = 1'b1; br = 1'b1;
    cycle("reset0", 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("reset1", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; clr();
    cycle("reset_idle", 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_load_use();
    hit(5'd5);
    cycle("ld_rs_hit", 1'b1, 1'b1, 1'b0, 1'b0);
    clr();
    cycle("ld_rs_c1", 1'b0, 1'b1, 1'b0, 1'b0);
    cycle("ld_rs_c2", 1'b0, 1'b1, 1'b0, 1'b0);
    cycle("ld_rs_c3", 1'b0, 1'b0, 1'b0, 1'b0);
    memrd = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd2;
    cycle("ld_rt_hit", 1'b1, 1'b1, 1'b0, 1'b0);
    clr();
    cycle("ld_rt_c1", 1'b0, 1'b1, 1'b0, 1'b0);
    cycle("ld_rt_c2", 1'b0, 1'b1, 1'b0, 1'b0);
    cycle("ld_rt_c3", 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_no_hazard();
    memrd = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    cycle("reg0", 1'b0, 1'b0, 1'b0, 1'b0);
    memrd = 1'b0; ex_rt = 5'd5; id_rs = 5'd5;
    cycle("not_load", 1'b0, 1'b0, 1'b0, 1'b0);
    memrd = 1'b1; ex_rt = 5'd5; id_rs = 5'd6; id_rt = 5'd4;
    cycle("no_match", 1'b0, 1'b0, 1'b0, 1'b0);
    clr();
  endtask

  task automatic test_reload();
    hit(5'd9);
    cycle("rl_c0", 1'b1, 1'b1, 1'b0, 1'b0);
    clr();
    cycle("rl_c1", 1'b0, 1'b1, 1'b0, 1'b0);
    hit(5'd9);
    cycle("rl_c2", 1'b1, 1'b1, 1'b0, 1'b0);
    clr();
    cycle("rl_c3", 1'b0, 1'b1, 1'b0, 1'b0);
    cycle("rl_c4", 1'b0, 1'b1, 1'b0, 1'b0);
    cycle("rl_c5", 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_mdu();
    for (int k = 0; k <= 10; k++) begin
      mdust = (k == 0);
      hilo  = (k >= 1 && k <= 9);
      cycle($sformatf("mdu_c%0d", k),
            k >= 1 && k <= 8, k >= 1 && k <= 4,
            k >= 1 && k <= 8, k >= 1 && k <= 4);
    end
    clr();
  endtask

  task automatic test_overlap();
    for (int k = 0; k <= 9; k++) begin
      clr();
      if (k == 0) begin
        hit(5'd3);
        mdust = 1'b1;
      end
      hilo = 1'b1;
      cycle($sformatf("ovl_c%0d", k),
            k <= 8, k <= 4,
            k >= 1 && k <= 8, k >= 1 && k <= 4);
    end
    clr();
  endtask

  task automatic test_restart();
    for (int k = 0; k <= 11; k++) begin
      mdust = (k == 0 || k == 2);
      cycle($sformatf("rst_md_c%0d", k), 1'b0, 1'b0,
            k >= 1 && k <= 10, k >= 1 && k <= 6);
    end
    clr();
  endtask

  task automatic test_branch();
    br = 1'b1;
    cycle("br_free", 1'b0, 1'b0, 1'b0, 1'b0);
    hit(5'd4);
    cycle("br_hit", 1'b1, 1'b1, 1'b0, 1'b0);
    memrd = 1'b0; ex_rt = 5'd0; id_rs = 5'd0;
    cycle("br_c2", 1'b0, 1'b1, 1'b0, 1'b0);
    cycle("br_c3", 1'b0, 1'b1, 1'b0, 1'b0);
    cycle("br_c4", 1'b0, 1'b0, 1'b0, 1'b0);
    clr();
  endtask

  task automatic test_reset_mid();
    hit(5'd5);
    cycle("rm_c0", 1'b1, 1'b1, 1'b0, 1'b0);
    clr();
    rst = 1'b1; hilo = 1'b1; br = 1'b1;
    cycle("rm_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; clr();
    cycle("rm_after", 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("rm_after2", 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_saturate();
    memrd = 1'b1; ex_rt = 5'd3; id_rt = 5'd3;
    for (int k = 0; k < 10; k++)
      cycle($sformatf("sat_c%0d", k), 1'b1, 1'b1, 1'b0, 1'b0);
    clr();
    cycle("sat_t1", 1'b0, 1'b1, 1'b0, 1'b0);
    cycle("sat_t2", 1'b0, 1'b1, 1'b0, 1'b0);
    cycle("sat_t3", 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    mca = '0;
    mcb = '0;
    rst = 1'b1;
    clr();
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_reload();
    test_mdu();
    test_overlap();
    test_restart();
    test_branch();
    test_reset_mid();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_AW, default 5, SHALL set register-specifier width.
REQ-002 Parameter LOAD_LAT, default 1, legal 1..15, SHALL set load-use stall cycles.
REQ-003 Parameter MDU_LAT, default 8, legal 1..255, SHALL set multiply/divide busy cycles.
REQ-004 Parameter CNT_W, default 16, SHALL set the stall performance counter width.
REQ-005 clk  in  1  SHALL be the single clock; all state on rising edge.
REQ-006 reset  in  1  SHALL be synchronous, active-high reset.
REQ-007 IDRegRs, IDRegRt  in  REG_AW  SHALL be the source registers of the ID-stage instruction.
REQ-008 EXRegRt  in  REG_AW  SHALL be the destination register of the EX-stage instruction.
REQ-009 EXMemRead  in  1  SHALL mark the EX-stage instruction as a load.
REQ-010 EXMduStart  in  1  SHALL pulse when the EX-stage instruction starts a multiply/divide.
REQ-011 IDHiLoUse  in  1  SHALL mark the ID instruction as reading HI/LO or issuing a multiply/divide.
REQ-012 IDBranchTaken  in  1  SHALL mark a taken branch/jump resolved in ID.
REQ-013 PCWrite, IFIDWrite  out  1  SHALL enable PC and IF/ID register update (1 = update).
REQ-014 HazMuxCon  out  1  SHALL select ID control (1) or a bubble into ID/EX (0).
REQ-015 IFIDFlush  out  1  SHALL zero the IF/ID register on the next edge.
REQ-016 MduBusy  out  1  SHALL be 1 while the multiply/divide counter is non-zero.
REQ-017 StallCycles  out  CNT_W  SHALL count stalled cycles since reset.

Function
REQ-018 Load-use hit SHALL be EXMemRead & (EXRegRt != 0) & (EXRegRt == IDRegRs | EXRegRt == IDRegRt); register 0 never causes a stall.
REQ-019 A load-use hit SHALL assert stall combinationally in the same cycle and load ld_cnt with LOAD_LAT-1.
REQ-020 While ld_cnt != 0, stall SHALL remain asserted and ld_cnt SHALL decrement by 1 per cycle; total load stall = LOAD_LAT cycles.
REQ-021 A new load-use hit while ld_cnt != 0 SHALL reload ld_cnt with LOAD_LAT-1.
REQ-022 EXMduStart SHALL load md_cnt with MDU_LAT; md_cnt != 0 SHALL decrement by 1 per cycle.
REQ-023 EXMduStart while md_cnt != 0 SHALL reload md_cnt with MDU_LAT (restart, no accumulation).
REQ-024 MDU hazard SHALL be IDHiLoUse & (md_cnt != 0); it SHALL assert stall combinationally.
REQ-025 stall = load-use hit | (ld_cnt != 0) | MDU hazard.
REQ-026 stall = 1 SHALL drive PCWrite=0, IFIDWrite=0, HazMuxCon=0; stall = 0 SHALL drive all three to 1.
REQ-027 IFIDFlush SHALL equal IDBranchTaken & ~stall; a branch during stall is not flushed and is re-evaluated after the stall.
REQ-028 Load and MDU stalls SHALL overlap without interaction; stall ends only when both sources clear.
REQ-029 StallCycles SHALL increment once per cycle with stall = 1 and saturate at 2^CNT_W-1.

Reset
REQ-030 While reset = 1, ld_cnt, md_cnt and StallCycles SHALL load 0 at the edge.
REQ-031 While reset = 1, outputs SHALL be PCWrite=0, IFIDWrite=0, HazMuxCon=0, IFIDFlush=0, MduBusy=0, regardless of inputs.
REQ-032 Reset mid-stall SHALL abort the stall; first cycle after reset with no hazard inputs SHALL give PCWrite=IFIDWrite=HazMuxCon=1.

Verification
REQ-033 LOAD_LAT=1: EXMemRead=1, EXRegRt=5, IDRegRs=5 for one cycle -> stall exactly 1 cycle; PCWrite=0, HazMuxCon=0; StallCycles=1.
REQ-034 LOAD_LAT=3: same hit, then EXMemRead=0 -> stall 3 consecutive cycles, then PCWrite=1; StallCycles=3.
REQ-035 EXMemRead=1, EXRegRt=0, IDRegRt=0 -> no stall, PCWrite=1.
REQ-036 MDU_LAT=8: EXMduStart at cycle 0, IDHiLoUse=1 from cycle 1 -> MduBusy cycles 1..8, stall cycles 1..8, release cycle 9.
REQ-037 IDBranchTaken=1 with no hazard -> IFIDFlush=1; with simultaneous load-use hit -> IFIDFlush=0, stall=1.
REQ-038 reset=1 during LOAD_LAT=3 stall second cycle -> next cycle counters 0, StallCycles=0, outputs per REQ-031; after release no stall.
